// File: rtl/rv64g_l2_probe_engine.sv
// Coherence probe sequencer: reads a directory entry, probes conflicting cores over
// TileLink B, collects C-channel acks, then writes the updated entry back.
module rv64g_l2_probe_engine #(
  parameter int SETS  = 256,
  parameter int WAYS  = 16,
  parameter int CORES = 4,
  localparam int SW = $clog2(SETS),
  localparam int WW = $clog2(WAYS),
  localparam int CW = $clog2(CORES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [SW-1:0]         req_set_i,
  input  logic [WW-1:0]         req_way_i,
  input  logic [CW-1:0]         req_core_i,
  input  logic                  req_excl_i,
  output logic [SW-1:0]         dir_rd_set_o,
  input  logic [WAYS-1:0]       dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0] dir_rd_sharers_i,
  input  logic [WAYS-1:0]       dir_rd_owner_valid_i,
  input  logic [WAYS*CW-1:0]    dir_rd_owner_id_i,
  input  logic [WAYS-1:0]       dir_rd_dirty_i,
  output logic                  dir_we_o,
  output logic [SW-1:0]         dir_wr_set_o,
  output logic [WW-1:0]         dir_wr_way_o,
  output logic                  dir_wr_valid_o,
  output logic [CORES-1:0]      dir_wr_sharers_o,
  output logic                  dir_wr_owner_valid_o,
  output logic [CW-1:0]         dir_wr_owner_id_o,
  output logic                  dir_wr_dirty_o,
  output logic                  probe_valid_o,
  input  logic                  probe_ready_i,
  output logic [CW-1:0]         probe_core_o,
  output logic [1:0]            probe_cap_o,
  input  logic                  pack_valid_i,
  input  logic [CW-1:0]         pack_core_i,
  input  logic                  pack_data_i,
  output logic                  done_o,
  output logic                  done_data_o,
  output logic                  err_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_PROBE  = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  localparam logic [1:0] CAP_TO_B = 2'd1;
  localparam logic [1:0] CAP_TO_N = 2'd2;

  state_e           state_q, state_d;
  logic [SW-1:0]    set_q, set_d;
  logic [WW-1:0]    way_q, way_d;
  logic [CW-1:0]    core_q, core_d;
  logic             excl_q, excl_d;
  logic [CORES-1:0] pending_q, pending_d;
  logic [CORES-1:0] outstanding_q, outstanding_d;
  logic             data_seen_q, data_seen_d;
  logic             err_q, err_d;
  logic [CORES-1:0] old_sharers_q, old_sharers_d;
  logic             old_ov_q, old_ov_d;
  logic [CW-1:0]    old_oid_q, old_oid_d;
  logic             old_dirty_q, old_dirty_d;
  logic             wr_valid_q, wr_valid_d;
  logic [CORES-1:0] wr_sharers_q, wr_sharers_d;
  logic             wr_ov_q, wr_ov_d;
  logic [CW-1:0]    wr_oid_q, wr_oid_d;
  logic             wr_dirty_q, wr_dirty_d;

  logic             entry_valid;
  logic [CORES-1:0] cur_sharers;
  logic             cur_ov;
  logic [CW-1:0]    cur_oid;
  logic             cur_dirty;
  logic [CORES-1:0] req_bit;
  logic [CORES-1:0] owner_bit;
  logic [CORES-1:0] probe_mask;
  logic             req_is_owner;
  logic [CW-1:0]    probe_idx;
  logic             probe_fire;
  logic [CORES-1:0] issue_bit;
  logic [CORES-1:0] ack_clr;
  logic             in_probe;

  assign in_probe = (state_q == ST_PROBE);

  // Entry fields: live from the directory during LOOKUP, from the captured copy afterwards.
  // An invalid entry reads as all-zero so stale fields never leak into the mask or write data.
  always_comb begin
    entry_valid = dir_rd_valid_i[way_q];
    cur_sharers = old_sharers_q;
    cur_ov      = old_ov_q;
    cur_oid     = old_oid_q;
    cur_dirty   = old_dirty_q;
    if (state_q == ST_LOOKUP) begin
      cur_sharers = entry_valid ? dir_rd_sharers_i[way_q*CORES +: CORES] : '0;
      cur_ov      = entry_valid & dir_rd_owner_valid_i[way_q];
      cur_oid     = entry_valid ? dir_rd_owner_id_i[way_q*CW +: CW] : '0;
      cur_dirty   = entry_valid & dir_rd_dirty_i[way_q];
    end
    req_bit      = CORES'(1) << core_q;
    req_is_owner = cur_ov && (cur_oid == core_q);
    owner_bit    = (cur_ov && !req_is_owner) ? (CORES'(1) << cur_oid) : '0;
    probe_mask   = excl_q ? ((cur_sharers & ~req_bit) | owner_bit) : owner_bit;
  end

  always_comb begin
    probe_idx = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (pending_q[i]) probe_idx = CW'(i);
    end
  end

  assign probe_fire = in_probe && (pending_q != '0) && probe_ready_i;
  assign issue_bit  = probe_fire ? (CORES'(1) << probe_idx) : '0;

  always_comb begin
    state_d       = state_q;
    set_d         = set_q;
    way_d         = way_q;
    core_d        = core_q;
    excl_d        = excl_q;
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    data_seen_d   = data_seen_q;
    err_d         = err_q;
    old_sharers_d = old_sharers_q;
    old_ov_d      = old_ov_q;
    old_oid_d     = old_oid_q;
    old_dirty_d   = old_dirty_q;
    wr_valid_d    = 1'b1;
    wr_sharers_d  = '0;
    wr_ov_d       = 1'b0;
    wr_oid_d      = '0;
    wr_dirty_d    = 1'b0;
    ack_clr       = '0;

    // Write-back image, only latched on the cycle that enters UPDATE.
    if (excl_q) begin
      wr_ov_d    = 1'b1;
      wr_oid_d   = core_q;
      wr_dirty_d = cur_dirty & (cur_oid == core_q);
    end else if (req_is_owner) begin
      wr_sharers_d = cur_sharers;
      wr_ov_d      = cur_ov;
      wr_oid_d     = cur_oid;
      wr_dirty_d   = cur_dirty;
    end else begin
      wr_sharers_d = cur_sharers | req_bit | owner_bit;
    end

    if (pack_valid_i) begin
      if (in_probe && outstanding_q[pack_core_i]) begin
        ack_clr     = CORES'(1) << pack_core_i;
        data_seen_d = data_seen_q | pack_data_i;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          set_d         = req_set_i;
          way_d         = req_way_i;
          core_d        = req_core_i;
          excl_d        = req_excl_i;
          pending_d     = '0;
          outstanding_d = '0;
          data_seen_d   = 1'b0;
          state_d       = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        old_sharers_d = cur_sharers;
        old_ov_d      = cur_ov;
        old_oid_d     = cur_oid;
        old_dirty_d   = cur_dirty;
        pending_d     = probe_mask;
        state_d       = (probe_mask == '0) ? ST_UPDATE : ST_PROBE;
      end
      ST_PROBE: begin
        pending_d     = pending_q & ~issue_bit;
        outstanding_d = (outstanding_q & ~ack_clr) | issue_bit;
        if (pending_d == '0 && outstanding_d == '0) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        pending_d     = '0;
        outstanding_d = '0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      set_q         <= '0;
      way_q         <= '0;
      core_q        <= '0;
      excl_q        <= 1'b0;
      pending_q     <= '0;
      outstanding_q <= '0;
      data_seen_q   <= 1'b0;
      err_q         <= 1'b0;
      old_sharers_q <= '0;
      old_ov_q      <= 1'b0;
      old_oid_q     <= '0;
      old_dirty_q   <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_sharers_q  <= '0;
      wr_ov_q       <= 1'b0;
      wr_oid_q      <= '0;
      wr_dirty_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      set_q         <= set_d;
      way_q         <= way_d;
      core_q        <= core_d;
      excl_q        <= excl_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      data_seen_q   <= data_seen_d;
      err_q         <= err_d;
      old_sharers_q <= old_sharers_d;
      old_ov_q      <= old_ov_d;
      old_oid_q     <= old_oid_d;
      old_dirty_q   <= old_dirty_d;
      if (state_d == ST_UPDATE && state_q != ST_UPDATE) begin
        wr_valid_q   <= wr_valid_d;
        wr_sharers_q <= wr_sharers_d;
        wr_ov_q      <= wr_ov_d;
        wr_oid_q     <= wr_oid_d;
        wr_dirty_q   <= wr_dirty_d;
      end
    end
  end

  logic upd;
  assign upd = (state_q == ST_UPDATE);

  assign req_ready_o          = (state_q == ST_IDLE);
  assign dir_rd_set_o         = (state_q == ST_LOOKUP) ? set_q : '0;
  assign dir_we_o             = upd;
  assign dir_wr_set_o         = upd ? set_q : '0;
  assign dir_wr_way_o         = upd ? way_q : '0;
  assign dir_wr_valid_o       = upd & wr_valid_q;
  assign dir_wr_sharers_o     = upd ? wr_sharers_q : '0;
  assign dir_wr_owner_valid_o = upd & wr_ov_q;
  assign dir_wr_owner_id_o    = upd ? wr_oid_q : '0;
  assign dir_wr_dirty_o       = upd & wr_dirty_q;
  assign probe_valid_o        = in_probe && (pending_q != '0);
  assign probe_core_o         = probe_valid_o ? probe_idx : '0;
  assign probe_cap_o          = probe_valid_o ? (excl_q ? CAP_TO_N : CAP_TO_B) : 2'd0;
  assign done_o               = upd;
  assign done_data_o          = upd & data_seen_q;
  assign err_o                = err_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_rv64g_l2_probe_engine.sv
// Directed bench for rv64g_l2_probe_engine: expected probes and directory writes are
// queued as requests are issued and popped by a negedge monitor.
module tb_rv64g_l2_probe_engine;
  localparam int SETS = 256, WAYS = 16, CORES = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_LOOKUP = 2'd1, S_PROBE = 2'd2, S_UPDATE = 2'd3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid_i = 1'b0, req_ready_o;
  logic [7:0] req_set_i = '0;
  logic [3:0] req_way_i = '0;
  logic [1:0] req_core_i = '0;
  logic req_excl_i = 1'b0;
  logic [7:0] dir_rd_set_o;
  logic [WAYS-1:0] dir_rd_valid_i, dir_rd_owner_valid_i, dir_rd_dirty_i;
  logic [WAYS*CORES-1:0] dir_rd_sharers_i;
  logic [WAYS*2-1:0] dir_rd_owner_id_i;
  logic dir_we_o, dir_wr_valid_o, dir_wr_owner_valid_o, dir_wr_dirty_o;
  logic [7:0] dir_wr_set_o;
  logic [3:0] dir_wr_way_o, dir_wr_sharers_o;
  logic [1:0] dir_wr_owner_id_o;
  logic probe_valid_o, probe_ready_i = 1'b1;
  logic [1:0] probe_core_o, probe_cap_o;
  logic pack_valid_i = 1'b0, pack_data_i = 1'b0;
  logic [1:0] pack_core_i = '0;
  logic done_o, done_data_o, err_o;
  logic [1:0] dbg_state;

  // Directory image seen by the DUT: only (t_set, t_way) holds the test entry.
  logic [7:0] t_set = '0;
  logic [3:0] t_way = '0, t_sharers = '0;
  logic t_valid = 1'b0, t_ov = 1'b0, t_dirty = 1'b0;
  logic [1:0] t_oid = '0;

  logic [21:0] exp_q[$];
  logic [3:0]  exp_probe_q[$];
  int errors = 0, checks = 0;

  rv64g_l2_probe_engine #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_set_i(req_set_i), .req_way_i(req_way_i), .req_core_i(req_core_i), .req_excl_i(req_excl_i),
    .dir_rd_set_o(dir_rd_set_o), .dir_rd_valid_i(dir_rd_valid_i), .dir_rd_sharers_i(dir_rd_sharers_i),
    .dir_rd_owner_valid_i(dir_rd_owner_valid_i), .dir_rd_owner_id_i(dir_rd_owner_id_i),
    .dir_rd_dirty_i(dir_rd_dirty_i),
    .dir_we_o(dir_we_o), .dir_wr_set_o(dir_wr_set_o), .dir_wr_way_o(dir_wr_way_o),
    .dir_wr_valid_o(dir_wr_valid_o), .dir_wr_sharers_o(dir_wr_sharers_o),
    .dir_wr_owner_valid_o(dir_wr_owner_valid_o), .dir_wr_owner_id_o(dir_wr_owner_id_o),
    .dir_wr_dirty_o(dir_wr_dirty_o),
    .probe_valid_o(probe_valid_o), .probe_ready_i(probe_ready_i),
    .probe_core_o(probe_core_o), .probe_cap_o(probe_cap_o),
    .pack_valid_i(pack_valid_i), .pack_core_i(pack_core_i), .pack_data_i(pack_data_i),
    .done_o(done_o), .done_data_o(done_data_o), .err_o(err_o), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      if (dir_rd_set_o == t_set && w == int'(t_way)) begin
        dir_rd_valid_i[w]          = t_valid;
        dir_rd_sharers_i[w*4 +: 4] = t_sharers;
        dir_rd_owner_valid_i[w]    = t_ov;
        dir_rd_owner_id_i[w*2 +: 2] = t_oid;
        dir_rd_dirty_i[w]          = t_dirty;
      end else begin
        dir_rd_valid_i[w]          = 1'b1;
        dir_rd_sharers_i[w*4 +: 4] = 4'b1111;
        dir_rd_owner_valid_i[w]    = 1'b1;
        dir_rd_owner_id_i[w*2 +: 2] = w[1:0];
        dir_rd_dirty_i[w]          = 1'b1;
      end
    end
  end

  function automatic logic [21:0] rec(logic [7:0] s, logic [3:0] w, logic v, logic [3:0] sh,
                                      logic ov, logic [1:0] oid, logic d, logic dd);
    return {s, w, v, sh, ov, oid, d, dd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every probe handshake and every directory write against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (probe_valid_o && probe_ready_i) begin
          if (exp_probe_q.size() == 0) chk("unexpected_probe", {28'd0, probe_core_o, probe_cap_o}, 32'hF0);
          else chk("probe", {28'd0, probe_core_o, probe_cap_o}, {28'd0, exp_probe_q.pop_front()});
        end
        if (dir_we_o) begin
          if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
          else chk("dir_write",
                   {10'd0, dir_wr_set_o, dir_wr_way_o, dir_wr_valid_o, dir_wr_sharers_o,
                    dir_wr_owner_valid_o, dir_wr_owner_id_o, dir_wr_dirty_o, done_data_o},
                   {10'd0, exp_q.pop_front()});
          chk("done_with_we", {31'd0, done_o}, 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic [7:0] s, input logic [3:0] w, input logic v,
                           input logic [3:0] sh, input logic ov, input logic [1:0] oid, input logic d);
    t_set = s; t_way = w; t_valid = v; t_sharers = sh; t_ov = ov; t_oid = oid; t_dirty = d;
  endtask

  task automatic send_req(input logic [7:0] s, input logic [3:0] w, input logic [1:0] c, input logic x);
    int n = 0;
    while (!req_ready_o && n < 30) begin
      tick();
      n++;
    end
    chk("req_ready_before_req", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_set_i = s; req_way_i = w; req_core_i = c; req_excl_i = x;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic ack(input logic [1:0] c, input logic d);
    pack_valid_i = 1'b1; pack_core_i = c; pack_data_i = d;
    tick();
    pack_valid_i = 1'b0; pack_data_i = 1'b0;
  endtask

  task automatic wait_probes();
    int n = 0;
    while (exp_probe_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("probes_drained", exp_probe_q.size(), 32'd0);
  endtask

  task automatic wait_write();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("write_seen", exp_q.size(), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_we", {31'd0, dir_we_o}, 32'd0);
    chk("rst_probe_valid", {31'd0, probe_valid_o}, 32'd0);
    chk("rst_done", {30'd0, done_o, done_data_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // 1: invalid entry, exclusive, no probes, fixed latency
    set_entry(8'd10, 4'd5, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b1);
    exp_q.push_back(rec(8'd10, 4'd5, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0));
    send_req(8'd10, 4'd5, 2'd1, 1'b1);
    chk("t1_lookup_state", {30'd0, dbg_state}, {30'd0, S_LOOKUP});
    chk("t1_rd_set", {24'd0, dir_rd_set_o}, 32'd10);
    chk("t1_c1_we", {31'd0, dir_we_o}, 32'd0);
    tick();
    chk("t1_c2_we", {31'd0, dir_we_o}, 32'd1);
    chk("t1_c2_done", {31'd0, done_o}, 32'd1);
    chk("t1_c2_probe", {31'd0, probe_valid_o}, 32'd0);
    tick();
    chk("t1_c3_ready", {31'd0, req_ready_o}, 32'd1);
    chk("t1_c3_we", {31'd0, dir_we_o}, 32'd0);

    // 2: sharers 1110, exclusive core0, acks out of order 3,1,2
    set_entry(8'd20, 4'd3, 1'b1, 4'b1110, 1'b0, 2'd0, 1'b0);
    exp_probe_q.push_back({2'd1, 2'd2});
    exp_probe_q.push_back({2'd2, 2'd2});
    exp_probe_q.push_back({2'd3, 2'd2});
    exp_q.push_back(rec(8'd20, 4'd3, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0));
    send_req(8'd20, 4'd3, 2'd0, 1'b1);
    wait_probes();
    ack(2'd3, 1'b0);
    ack(2'd1, 1'b0);
    chk("t2_no_we_before_last_ack", {31'd0, dir_we_o}, 32'd0);
    ack(2'd2, 1'b0);
    chk("t2_we_after_last_ack", {31'd0, dir_we_o}, 32'd1);
    wait_write();

    // 3: owner core2 dirty, shared req core3, ProbeAckData
    set_entry(8'd33, 4'd7, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1);
    exp_probe_q.push_back({2'd2, 2'd1});
    exp_q.push_back(rec(8'd33, 4'd7, 1'b1, 4'b1100, 1'b0, 2'd0, 1'b0, 1'b1));
    send_req(8'd33, 4'd7, 2'd3, 1'b0);
    wait_probes();
    ack(2'd2, 1'b1);
    chk("t3_done_data", {31'd0, done_data_o}, 32'd1);
    wait_write();

    // 4: probe backpressure for 5 cycles
    probe_ready_i = 1'b0;
    set_entry(8'd40, 4'd0, 1'b1, 4'b0011, 1'b0, 2'd2, 1'b0);
    exp_probe_q.push_back({2'd0, 2'd2});
    exp_probe_q.push_back({2'd1, 2'd2});
    exp_q.push_back(rec(8'd40, 4'd0, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b1));
    send_req(8'd40, 4'd0, 2'd2, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", {31'd0, probe_valid_o}, 32'd1);
      chk("t4_stall_core_cap", {28'd0, probe_core_o, probe_cap_o}, {28'd0, 2'd0, 2'd2});
      chk("t4_stall_state", {30'd0, dbg_state}, {30'd0, S_PROBE});
      tick();
    end
    probe_ready_i = 1'b1;
    wait_probes();
    ack(2'd0, 1'b0);
    ack(2'd1, 1'b1);
    wait_write();

    // 5: unexpected ack sets sticky err_o
    set_entry(8'd50, 4'd9, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
    exp_probe_q.push_back({2'd2, 2'd1});
    exp_q.push_back(rec(8'd50, 4'd9, 1'b1, 4'b0110, 1'b0, 2'd0, 1'b0, 1'b0));
    chk("t5_err_before", {31'd0, err_o}, 32'd0);
    send_req(8'd50, 4'd9, 2'd1, 1'b0);
    wait_probes();
    ack(2'd0, 1'b0);
    chk("t5_err_set", {31'd0, err_o}, 32'd1);
    chk("t5_no_we_on_bad_ack", {31'd0, dir_we_o}, 32'd0);
    ack(2'd2, 1'b0);
    chk("t5_we_on_good_ack", {31'd0, dir_we_o}, 32'd1);
    tick();
    chk("t5_err_sticky", {31'd0, err_o}, 32'd1);

    // Shared request from the current owner on way 15: no probe, entry kept
    set_entry(8'd60, 4'd15, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1);
    exp_q.push_back(rec(8'd60, 4'd15, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b1, 1'b0));
    send_req(8'd60, 4'd15, 2'd3, 1'b0);
    wait_write();

    // Exclusive from the dirty owner: keeps dirty, probes other sharer only
    set_entry(8'd70, 4'd2, 1'b1, 4'b1001, 1'b1, 2'd0, 1'b1);
    exp_probe_q.push_back({2'd3, 2'd2});
    exp_q.push_back(rec(8'd70, 4'd2, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0));
    send_req(8'd70, 4'd2, 2'd0, 1'b1);
    wait_probes();
    ack(2'd3, 1'b0);
    wait_write();

    // 6: reset in PROBE abandons the transaction
    probe_ready_i = 1'b0;
    set_entry(8'd80, 4'd1, 1'b1, 4'b0101, 1'b0, 2'd0, 1'b0);
    send_req(8'd80, 4'd1, 2'd1, 1'b1);
    tick();
    chk("t6_in_probe", {31'd0, probe_valid_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_probe_valid", {31'd0, probe_valid_o}, 32'd0);
    chk("t6_rst_we_done", {30'd0, dir_we_o, done_o}, 32'd0);
    chk("t6_rst_err_clear", {31'd0, err_o}, 32'd0);
    chk("t6_rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    tick(); tick();
    rst_n = 1'b1;
    probe_ready_i = 1'b1;
    tick();
    chk("t6_ready_after", {31'd0, req_ready_o}, 32'd1);
    chk("t6_no_we_after", {31'd0, dir_we_o}, 32'd0);
    set_entry(8'd255, 4'd0, 1'b0, 4'b1010, 1'b1, 2'd1, 1'b1);
    exp_q.push_back(rec(8'd255, 4'd0, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0));
    send_req(8'd255, 4'd0, 2'd2, 1'b0);
    wait_write();

    // Ack while idle is unexpected
    tick();
    ack(2'd1, 1'b0);
    chk("idle_ack_err", {31'd0, err_o}, 32'd1);

    tick(); tick();
    chk("final_write_q_empty", exp_q.size(), 32'd0);
    chk("final_probe_q_empty", exp_probe_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
